// File: rtl/wb_spm_host_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wb_spm_host_master                                            |
// | Brief    : Single-outstanding Wishbone pipelined master, cmd/rsp streams |
// |            Optional macro WB_HOST_TIMEOUT_EN enables the timeout abort.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module wb_spm_host_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_WAIT = 2'd2;
  localparam logic [1:0] c_RESP = 2'd3;

  logic [1:0] r_state;
  logic       w_busy;
  logic       w_ack_ok;
  logic       w_timeout;

  assign cmd_ready = (r_state == c_IDLE);
  assign w_busy    = (r_state == c_REQ) || (r_state == c_WAIT);
  // An ack only counts once the request has actually been taken by the slave.
  assign w_ack_ok  = ((r_state == c_REQ) && !i_wb_stall && i_wb_ack) ||
                     ((r_state == c_WAIT) && i_wb_ack);

`ifdef WB_HOST_TIMEOUT_EN
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if ((r_state == c_IDLE) && cmd_valid) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = w_busy && (r_cnt == c_CNT_LAST);
`else
  logic w_unused_params;
  assign w_unused_params = (TIMEOUT_CYCLES > 0) && (CNT_W > 0);
  assign w_timeout       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_IDLE;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= 32'd0;
      o_wb_data <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (cmd_valid) begin
            o_wb_we   <= cmd_we;
            o_wb_addr <= cmd_addr;
            o_wb_data <= cmd_data;
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            r_state   <= c_REQ;
          end
        end
        c_REQ, c_WAIT: begin
          // Completion has priority over the timeout abort on the same edge.
          if (w_ack_ok) begin
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            rsp_data  <= o_wb_we ? 32'd0 : i_wb_data;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            r_state   <= c_RESP;
          end else if (w_timeout) begin
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            r_state   <= c_RESP;
          end else if ((r_state == c_REQ) && !i_wb_stall) begin
            o_wb_stb  <= 1'b0;
            r_state   <= c_WAIT;
          end
        end
        c_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_spm_host_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_wb_spm_host_master                                         |
// | Brief    : Self-checking bench; per-transaction timeline reference model |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_wb_spm_host_master;

  localparam int TC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_addr = 32'd0, cmd_data = 32'd0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_data;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic        i_wb_ack = 1'b0, i_wb_stall = 1'b0;
  logic [31:0] i_wb_data = 32'd0;

  always #5 clk = ~clk;

  wb_spm_host_master #(.TIMEOUT_CYCLES(TC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
  );

  int vectors = 0;
  int miscompares = 0;

  // Expected outputs for the current cycle, written by the stimulus tasks.
  logic        chk_en = 1'b0;
  logic        e_cyc = 1'b0, e_stb = 1'b0, e_we = 1'b0, e_rdy = 1'b1, e_rv = 1'b0, e_re = 1'b0;
  logic [31:0] e_addr = 32'd0, e_data = 32'd0, e_rd = 32'd0;

  int          stb_len = 0, cyc_len = 0, last_stb_len = 0, last_cyc_len = 0;
  logic [31:0] last_rsp_data = 32'd0;
  logic        last_rsp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(e_rdy));
      chk("wb_cyc",    32'(o_wb_cyc),  32'(e_cyc));
      chk("wb_stb",    32'(o_wb_stb),  32'(e_stb));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_cyc) begin
        chk("wb_we",   32'(o_wb_we), 32'(e_we));
        chk("wb_addr", o_wb_addr, e_addr);
        chk("wb_data", o_wb_data, e_data);
      end
      if (e_rv) begin
        chk("rsp_data", rsp_data, e_rd);
        chk("rsp_err",  32'(rsp_err), 32'(e_re));
      end
    end
  end

  always @(negedge clk) begin
    if (o_wb_stb) stb_len++;
    else if (stb_len != 0) begin last_stb_len = stb_len; stb_len = 0; end
    if (o_wb_cyc) cyc_len++;
    else if (cyc_len != 0) begin last_cyc_len = cyc_len; cyc_len = 0; end
    if (rsp_valid) begin last_rsp_data = rsp_data; last_rsp_err = rsp_err; end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_cyc = 1'b0; e_stb = 1'b0; e_rdy = 1'b1; e_rv = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input logic ack_val);
    for (int g = 0; g < n; g++) begin
      cmd_valid  = 1'b0;
      i_wb_ack   = ack_val;
      i_wb_stall = 1'($urandom_range(0, 1));
      i_wb_data  = $urandom;
      rsp_ready  = 1'($urandom_range(0, 1));
      set_idle_exp();
      step();
    end
  endtask

  // One transaction: S stall cycles, ack A cycles after acceptance, R cycles of
  // response backpressure. Timeline is derived from the rules, not the FSM.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int S, input int A, input int R,
                         input int gap, input logic no_ack);
    int   end_k;
    logic err;
    idle_cycles(gap, 1'($urandom_range(0, 1)));
    err   = 1'b0;
    end_k = no_ack ? (1 << 30) : (S + A);
`ifdef WB_HOST_TIMEOUT_EN
    if (end_k > TC - 1) begin end_k = TC - 1; err = 1'b1; end
`endif
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_data = data;
    i_wb_ack  = 1'($urandom_range(0, 1));
    rsp_ready = 1'($urandom_range(0, 1));
    set_idle_exp();
    step();
    for (int k = 0; k <= end_k; k++) begin
      i_wb_stall = (k < S) ? 1'b1 : ((k == S) ? 1'b0 : 1'($urandom_range(0, 1)));
      i_wb_ack   = (k < S) ? 1'($urandom_range(0, 1)) : (!no_ack && (k == S + A));
      i_wb_data  = (k == S + A) ? rdata : $urandom;
      cmd_valid  = 1'b1; cmd_we = 1'($urandom_range(0, 1));
      cmd_addr   = $urandom; cmd_data = $urandom;
      rsp_ready  = 1'($urandom_range(0, 1));
      e_cyc = 1'b1; e_stb = (k <= S); e_we = we; e_addr = addr; e_data = data;
      e_rdy = 1'b0; e_rv = 1'b0;
      step();
    end
    for (int j = 0; j <= R; j++) begin
      rsp_ready  = (j == R);
      cmd_valid  = 1'b1; cmd_addr = $urandom; cmd_data = $urandom;
      i_wb_ack   = 1'($urandom_range(0, 1));
      i_wb_stall = 1'($urandom_range(0, 1));
      i_wb_data  = $urandom;
      e_cyc = 1'b0; e_stb = 1'b0; e_rdy = 1'b0; e_rv = 1'b1;
      e_rd  = (err || we) ? 32'd0 : rdata;
      e_re  = err;
      step();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; i_wb_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc",       32'(o_wb_cyc),  32'd0);
    chk("rst_stb",       32'(o_wb_stb),  32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  rsp_data,       32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b1;
    set_idle_exp();
    chk_en = 1'b1;
    step();

    // Write, ack one cycle after acceptance.
    run_txn(1'b1, 32'h3000_0000, 32'h0000_00A5, 32'd0, 0, 1, 0, 1, 1'b0);
    chk("wr_stb_len", 32'(last_stb_len), 32'd1);
    chk("wr_cyc_len", 32'(last_cyc_len), 32'd2);
    chk("wr_rsp_data", last_rsp_data, 32'd0);
    chk("wr_rsp_err", 32'(last_rsp_err), 32'd0);

    // Read.
    run_txn(1'b0, 32'h3000_0004, 32'h1234_5678, 32'h0000_3C12, 0, 1, 0, 0, 1'b0);
    chk("rd_rsp_data", last_rsp_data, 32'h0000_3C12);
    chk("rd_rsp_err", 32'(last_rsp_err), 32'd0);

    // Stall three cycles after stb rises.
    run_txn(1'b1, 32'h3000_0008, 32'hDEAD_BEEF, 32'd0, 3, 1, 0, 1, 1'b0);
    chk("stall_stb_len", 32'(last_stb_len), 32'd4);

    // Same-cycle accept and ack.
    run_txn(1'b0, 32'h3000_000C, 32'd0, 32'hCAFE_0001, 0, 0, 0, 0, 1'b0);
    chk("ack0_cyc_len", 32'(last_cyc_len), 32'd1);

`ifdef WB_HOST_TIMEOUT_EN
    // Unmapped read with no ack aborts after TC cycles; stray idle ack ignored.
    run_txn(1'b0, 32'h3000_0010, 32'd0, 32'd0, 0, 0, 0, 1, 1'b1);
    chk("to_cyc_len", 32'(last_cyc_len), 32'd16);
    chk("to_rsp_err", 32'(last_rsp_err), 32'd1);
    chk("to_rsp_data", last_rsp_data, 32'd0);
    idle_cycles(3, 1'b1);
    // Ack on the final counted cycle wins over the abort.
    run_txn(1'b0, 32'h3000_0014, 32'd0, 32'h0BAD_F00D, 3, TC - 4, 0, 0, 1'b0);
    chk("to_edge_err", 32'(last_rsp_err), 32'd0);
`endif

    // Response backpressure for 5 cycles, next command right after.
    run_txn(1'b0, 32'h3000_0018, 32'd0, 32'h5555_AAAA, 0, 2, 5, 0, 1'b0);
    run_txn(1'b1, 32'h3000_001C, 32'h0000_0077, 32'd0, 1, 0, 0, 0, 1'b0);

    // Reset asserted while waiting for ack.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h3000_0020; cmd_data = 32'h0;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0;
    set_idle_exp();
    step();
    cmd_valid = 1'b0;
    e_cyc = 1'b1; e_stb = 1'b1; e_we = 1'b0; e_addr = 32'h3000_0020; e_data = 32'h0;
    e_rdy = 1'b0; e_rv = 1'b0;
    step();
    e_stb = 1'b0;
    #2;
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_cyc",       32'(o_wb_cyc),  32'd0);
    chk("arst_stb",       32'(o_wb_stb),  32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    set_idle_exp();
    step();
    chk_en = 1'b1;
    run_txn(1'b1, 32'h3000_0024, 32'h0000_1111, 32'd0, 0, 1, 0, 0, 1'b0);
    chk("post_rst_err", 32'(last_rsp_err), 32'd0);

    // Randomised traffic.
    for (int t = 0; t < 150; t++) begin
      logic na;
      int   s_max;
      na    = 1'b0;
      s_max = 4;
`ifdef WB_HOST_TIMEOUT_EN
      na    = ($urandom_range(0, 7) == 0);
      s_max = 18;
`endif
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              int'($urandom_range(0, s_max)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), na);
    end

    idle_cycles(2, 1'b0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
